// File: rtl/memory_16x8_loader.sv
// memory_16x8_loader: writable 16x8 SAP-1 memory with a sequential byte-stream load port and ROM-compatible read port
module memory_16x8_loader #(
  parameter int ROM_WIDTH    = 8,
  parameter int ROM_DEPTH    = 16,
  parameter int ADDRESS_SIZE = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    loadStart,
  input  logic [ROM_WIDTH-1:0]    loadData,
  input  logic                    loadValid,
  output logic                    loadReady,
  output logic                    loadBusy,
  output logic                    loadDone,
  output logic [ADDRESS_SIZE:0]   loadCount,
  input  logic                    readEnable,
  input  logic [ADDRESS_SIZE-1:0] readAddress,
  output logic [ROM_WIDTH-1:0]    dataOut
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t                  state_q, state_d;
  logic [ADDRESS_SIZE-1:0] ptr_q, ptr_d;
  logic [ADDRESS_SIZE:0]   cnt_q, cnt_d;
  logic [ROM_WIDTH-1:0]    dout_q;
  logic                    we;
  logic [ROM_WIDTH-1:0]    mem [ROM_DEPTH];
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    if (loadStart) begin
      state_d = LOAD;
      ptr_d   = '0;
      cnt_d   = '0;
    end else if (state_q == LOAD && loadValid) begin
      we      = 1'b1;
      ptr_d   = ptr_q + 1'b1;
      cnt_d   = cnt_q + 1'b1;
      state_d = (ptr_q == ADDRESS_SIZE'(ROM_DEPTH - 1)) ? DONE : LOAD;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      if (state_q != LOAD && readEnable) dout_q <= mem[readAddress];
    end
  end
  // Memory contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we) mem[ptr_q] <= loadData;
  end
  assign loadReady = (state_q == LOAD);
  assign loadBusy  = (state_q == LOAD);
  assign loadDone  = (state_q == DONE);
  assign loadCount = cnt_q;
  assign dataOut   = dout_q;
endmodule

// File: tb/tb_memory_16x8_loader.sv
// tb_memory_16x8_loader: table-driven and scoreboard checks of the loadable 16x8 memory
module tb_memory_16x8_loader;
  logic       clk = 0, reset = 1, loadStart = 0, loadValid = 0, readEnable = 0;
  logic [7:0] loadData = 0, dataOut;
  logic [3:0] readAddress = 0;
  logic       loadReady, loadBusy, loadDone;
  logic [4:0] loadCount;
  int         checks = 0, errors = 0, mptr = 0, acc;
  logic [7:0] mdl [16];
  logic [7:0] exp_q [$];
  typedef struct {logic [7:0] d; logic [4:0] cnt; logic done;} vec_t;
  vec_t       tbl [16];
  logic [7:0] bytes [16] = '{8'h09, 8'h1A, 8'h1B, 8'h2C, 8'hEF, 8'h09, 8'h1C, 8'hEF,
                             8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'hFF};

  memory_16x8_loader dut (
    .clk(clk), .reset(reset), .loadStart(loadStart), .loadData(loadData),
    .loadValid(loadValid), .loadReady(loadReady), .loadBusy(loadBusy),
    .loadDone(loadDone), .loadCount(loadCount), .readEnable(readEnable),
    .readAddress(readAddress), .dataOut(dataOut)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic start;
    loadStart = 1;
    step;
    loadStart = 0;
    mptr = 0;
    chk("start_busy", loadBusy, 1);
    chk("start_cnt", loadCount, 0);
  endtask

  task automatic feed(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      loadValid = 1;
      loadData = base + 8'(i);
      chk("feed_ready", loadReady, 1);
      step;
      mdl[mptr] = loadData;
      mptr++;
      chk("feed_cnt", loadCount, mptr);
    end
    loadValid = 0;
  endtask

  task automatic rd(input logic [3:0] a);
    readEnable = 1;
    readAddress = a;
    exp_q.push_back(mdl[a]);
    step;
    readEnable = 0;
    chk($sformatf("rd%0d", a), dataOut, exp_q.pop_front());
  endtask

  task automatic chk_reset;
    chk("rst_ready", loadReady, 0);
    chk("rst_busy", loadBusy, 0);
    chk("rst_done", loadDone, 0);
    chk("rst_cnt", loadCount, 0);
    chk("rst_dout", dataOut, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tbl[i] = '{bytes[i], 5'(i + 1), i == 15};
    step;
    step;
    reset = 0;
    chk_reset;

    // Full load with valid held high, then a 17th valid byte that must be dropped
    start;
    for (int i = 0; i < 16; i++) begin
      loadValid = 1;
      loadData = tbl[i].d;
      chk("tbl_ready", loadReady, 1);
      step;
      mdl[i] = tbl[i].d;
      chk("tbl_cnt", loadCount, tbl[i].cnt);
      chk("tbl_done", loadDone, tbl[i].done);
    end
    chk("after_ready", loadReady, 0);
    chk("after_busy", loadBusy, 0);
    loadData = 8'h55;
    step;
    loadValid = 0;
    chk("x17_cnt", loadCount, 16);
    chk("x17_done", loadDone, 1);
    chk("x17_ready", loadReady, 0);
    for (int a = 0; a < 16; a++) rd(4'(a));

    // Preload 0xAA at address 5, then a gapped load with reads held during LOAD
    start;
    feed(5, 8'hA0);
    feed(1, 8'hAA);
    feed(10, 8'hA6);
    chk("pre_done", loadDone, 1);
    rd(5);
    start;
    readEnable = 1;
    readAddress = 5;
    acc = 0;
    for (int c = 0; c < 100 && !loadDone; c++) begin
      loadValid = (c % 3 == 2);
      loadData = 8'h30 + 8'(acc);
      step;
      if (loadValid) begin
        mdl[acc] = loadData;
        acc++;
      end
      chk("gap_cnt", loadCount, acc);
      chk("gap_hold", dataOut, 8'hAA);
    end
    loadValid = 0;
    readEnable = 0;
    chk("gap_done", loadDone, 1);
    chk("gap_total", acc, 16);
    rd(5);

    // Restart after 7 accepts; loadStart with valid from DONE writes nothing
    loadStart = 1;
    loadValid = 1;
    loadData = 8'hEE;
    step;
    loadStart = 0;
    loadValid = 0;
    mptr = 0;
    chk("dstart_done", loadDone, 0);
    chk("dstart_cnt", loadCount, 0);
    feed(7, 8'h70);
    loadStart = 1;
    loadValid = 1;
    loadData = 8'hEE;
    step;
    loadStart = 0;
    loadValid = 0;
    mptr = 0;
    chk("restart_cnt", loadCount, 0);
    chk("restart_busy", loadBusy, 1);
    feed(15, 8'h80);
    chk("restart_notdone", loadDone, 0);
    feed(1, 8'h8F);
    chk("restart_done", loadDone, 1);
    rd(0);
    rd(6);
    rd(15);

    // Reset after 4 accepts keeps written bytes but clears control state
    start;
    feed(4, 8'hC0);
    reset = 1;
    step;
    reset = 0;
    mptr = 0;
    chk_reset;
    for (int a = 0; a < 5; a++) rd(4'(a));
    chk("old_a4", dataOut, 8'h84);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
